// File: rtl/axis_channel_packer.sv
// axis_channel_packer
//
// Purpose: snapshots the six selector channel words on a trigger and sends them
// as one framed AXI-Stream packet: an optional header beat followed by the
// enabled channels in ascending order, with back-pressure on M_AXIS_tready.
// Triggers that arrive while a frame is in flight are dropped and counted.
//
// Ports:
//   a_clk, a_rst             clock, asynchronous active-high reset
//   S_AXIS_n_tdata/tvalid    channel n word and valid flag (n = 1..6), sampled only
//   trigger                  one-cycle request for a snapshot and a frame
//   channel_mask             bit n-1 enables channel n in the frame
//   M_AXIS_tdata/tvalid/
//   tready/tlast             framed output stream
//   busy                     high while a frame is being sent
//   overrun_count            dropped triggers, saturating at 0xFFFF
//   frame_count              frames whose first beat was accepted, wrapping
//
// Header beat layout (32 bits):
//   {frame_count[15:0], 2'b00, snap_valid[5:0], 2'b00, snap_mask[5:0]}
module axis_channel_packer #(
    parameter int SAXIS_TDATA_WIDTH = 32,
    parameter int MAXIS_TDATA_WIDTH = 32,
    parameter int HEADER_EN         = 1
) (
    input  logic                         a_clk,
    input  logic                         a_rst,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_1_tdata,
    input  logic                         S_AXIS_1_tvalid,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_2_tdata,
    input  logic                         S_AXIS_2_tvalid,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_3_tdata,
    input  logic                         S_AXIS_3_tvalid,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_4_tdata,
    input  logic                         S_AXIS_4_tvalid,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_5_tdata,
    input  logic                         S_AXIS_5_tvalid,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_6_tdata,
    input  logic                         S_AXIS_6_tvalid,
    input  logic                         trigger,
    input  logic [5:0]                   channel_mask,
    output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                         M_AXIS_tvalid,
    input  logic                         M_AXIS_tready,
    output logic                         M_AXIS_tlast,
    output logic                         busy,
    output logic [15:0]                  overrun_count,
    output logic [15:0]                  frame_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]                   r_state;
    logic [SAXIS_TDATA_WIDTH-1:0] r_snap_data [6];
    logic [5:0]                   r_snap_valid;
    logic [5:0]                   r_snap_mask;
    logic [5:0]                   r_pend;
    logic [MAXIS_TDATA_WIDTH-1:0] r_tdata;
    logic                         r_tvalid;
    logic                         r_tlast;
    logic                         r_first;
    logic [15:0]                  r_overrun;
    logic [15:0]                  r_frames;

    logic [SAXIS_TDATA_WIDTH-1:0] w_in_data [6];
    logic [5:0]                   w_in_valid;
    logic                         w_xfer;
    logic                         w_last_xfer;
    logic                         w_accept;
    logic                         w_overrun;
    logic                         w_first_xfer;
    logic [15:0]                  w_frames_nxt;
    logic [31:0]                  w_hdr;
    logic [2:0]                   w_start_idx;
    logic [5:0]                   w_start_rest;
    logic [MAXIS_TDATA_WIDTH-1:0] w_start_data;
    logic                         w_start_last;
    logic [5:0]                   w_start_pend;
    logic [2:0]                   w_next_idx;
    logic [5:0]                   w_next_rest;
    logic [MAXIS_TDATA_WIDTH-1:0] w_next_data;
    logic                         w_next_last;
    logic                         w_unused_snapshot;

    // Index of the lowest set bit; the channel that goes out next.
    function automatic logic [2:0] lowest_idx(input logic [5:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Channel words are zero-extended onto the output bus.
    function automatic logic [MAXIS_TDATA_WIDTH-1:0] widen(input logic [SAXIS_TDATA_WIDTH-1:0] d);
        logic [MAXIS_TDATA_WIDTH-1:0] w;
        w = '0;
        w[SAXIS_TDATA_WIDTH-1:0] = d;
        return w;
    endfunction

    assign w_in_data[0] = S_AXIS_1_tdata;
    assign w_in_data[1] = S_AXIS_2_tdata;
    assign w_in_data[2] = S_AXIS_3_tdata;
    assign w_in_data[3] = S_AXIS_4_tdata;
    assign w_in_data[4] = S_AXIS_5_tdata;
    assign w_in_data[5] = S_AXIS_6_tdata;
    assign w_in_valid   = {S_AXIS_6_tvalid, S_AXIS_5_tvalid, S_AXIS_4_tvalid,
                           S_AXIS_3_tvalid, S_AXIS_2_tvalid, S_AXIS_1_tvalid};

    assign w_xfer       = r_tvalid & M_AXIS_tready;
    assign w_last_xfer  = w_xfer & r_tlast;
    // A trigger is taken in IDLE or on the cycle the tlast beat leaves,
    // which is what makes back-to-back frames gap-free.
    assign w_accept     = trigger & (|channel_mask) & ((r_state == ST_IDLE) | w_last_xfer);
    assign w_overrun    = trigger & (r_state == ST_SEND) & ~w_last_xfer;
    assign w_first_xfer = w_xfer & r_first;
    assign w_frames_nxt = r_frames + 16'(w_first_xfer);

    // The header is built at accept time and must carry the count as it will
    // stand when the header itself is accepted, so it uses the post-edge value
    // (a one-beat previous frame may be incrementing it in this same cycle).
    assign w_hdr = {w_frames_nxt, 2'b00, w_in_valid, 2'b00, channel_mask};

    always_comb begin
        w_start_idx  = lowest_idx(channel_mask);
        w_start_rest = channel_mask & ~(6'b1 << w_start_idx);
        if (HEADER_EN != 0) begin
            w_start_data = MAXIS_TDATA_WIDTH'(w_hdr);
            w_start_last = 1'b0;
            w_start_pend = channel_mask;
        end else begin
            w_start_data = widen(w_in_data[w_start_idx]);
            w_start_last = (w_start_rest == 6'd0);
            w_start_pend = w_start_rest;
        end
    end

    always_comb begin
        w_next_idx  = lowest_idx(r_pend);
        w_next_rest = r_pend & ~(6'b1 << w_next_idx);
        w_next_data = widen(r_snap_data[w_next_idx]);
        w_next_last = (w_next_rest == 6'd0);
    end

    // The valid/mask snapshot is already folded into the header beat at accept
    // time; the registers remain as a record of the frame being sent.
    assign w_unused_snapshot = ^{r_snap_valid, r_snap_mask};

    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) begin
            r_state      <= ST_IDLE;
            r_snap_valid <= '0;
            r_snap_mask  <= '0;
            r_pend       <= '0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_first      <= 1'b0;
            r_overrun    <= '0;
            r_frames     <= '0;
            for (int i = 0; i < 6; i++) begin
                r_snap_data[i] <= '0;
            end
        end else begin
            r_frames <= w_frames_nxt;
            if (w_overrun && (r_overrun != 16'hFFFF)) begin
                r_overrun <= r_overrun + 16'd1;
            end

            if (w_accept) begin
                r_state      <= ST_SEND;
                r_snap_valid <= w_in_valid;
                r_snap_mask  <= channel_mask;
                for (int i = 0; i < 6; i++) begin
                    r_snap_data[i] <= w_in_data[i];
                end
                r_tvalid <= 1'b1;
                r_tdata  <= w_start_data;
                r_tlast  <= w_start_last;
                r_pend   <= w_start_pend;
                r_first  <= 1'b1;
            end else if (w_xfer) begin
                r_first <= 1'b0;
                if (r_tlast) begin
                    r_state  <= ST_IDLE;
                    r_tvalid <= 1'b0;
                    r_tlast  <= 1'b0;
                end else begin
                    // Disabled channels never occupy a cycle: the next
                    // pending channel is picked directly.
                    r_tdata <= w_next_data;
                    r_tlast <= w_next_last;
                    r_pend  <= w_next_rest;
                end
            end
        end
    end

    assign M_AXIS_tdata  = r_tdata;
    assign M_AXIS_tvalid = r_tvalid;
    assign M_AXIS_tlast  = r_tlast;
    assign busy          = (r_state == ST_SEND);
    assign overrun_count = r_overrun;
    assign frame_count   = r_frames;

endmodule

// File: tb/tb_axis_channel_packer.sv
module tb_axis_channel_packer;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic        a_clk = 1'b0;
    logic        a_rst = 1'b1;
    logic [31:0] s_data [6];
    logic [5:0]  s_valid;
    logic        trigger = 1'b0;
    logic        trigger0 = 1'b0;
    logic [5:0]  channel_mask = 6'd0;
    logic        tready = 1'b1;
    logic        tready0 = 1'b1;

    logic [31:0] m_tdata, m0_tdata;
    logic        m_tvalid, m0_tvalid;
    logic        m_tlast, m0_tlast;
    logic        busy, busy0;
    logic [15:0] ovr, ovr0;
    logic [15:0] fc, fc0;

    beat_t q[$];
    beat_t q0[$];
    int    checks = 0;
    int    errors = 0;

    always #5 a_clk = ~a_clk;

    axis_channel_packer #(
        .SAXIS_TDATA_WIDTH(32), .MAXIS_TDATA_WIDTH(32), .HEADER_EN(1)
    ) dut (
        .a_clk(a_clk), .a_rst(a_rst),
        .S_AXIS_1_tdata(s_data[0]), .S_AXIS_1_tvalid(s_valid[0]),
        .S_AXIS_2_tdata(s_data[1]), .S_AXIS_2_tvalid(s_valid[1]),
        .S_AXIS_3_tdata(s_data[2]), .S_AXIS_3_tvalid(s_valid[2]),
        .S_AXIS_4_tdata(s_data[3]), .S_AXIS_4_tvalid(s_valid[3]),
        .S_AXIS_5_tdata(s_data[4]), .S_AXIS_5_tvalid(s_valid[4]),
        .S_AXIS_6_tdata(s_data[5]), .S_AXIS_6_tvalid(s_valid[5]),
        .trigger(trigger), .channel_mask(channel_mask),
        .M_AXIS_tdata(m_tdata), .M_AXIS_tvalid(m_tvalid), .M_AXIS_tready(tready),
        .M_AXIS_tlast(m_tlast), .busy(busy), .overrun_count(ovr), .frame_count(fc)
    );

    axis_channel_packer #(
        .SAXIS_TDATA_WIDTH(32), .MAXIS_TDATA_WIDTH(32), .HEADER_EN(0)
    ) dut0 (
        .a_clk(a_clk), .a_rst(a_rst),
        .S_AXIS_1_tdata(s_data[0]), .S_AXIS_1_tvalid(s_valid[0]),
        .S_AXIS_2_tdata(s_data[1]), .S_AXIS_2_tvalid(s_valid[1]),
        .S_AXIS_3_tdata(s_data[2]), .S_AXIS_3_tvalid(s_valid[2]),
        .S_AXIS_4_tdata(s_data[3]), .S_AXIS_4_tvalid(s_valid[3]),
        .S_AXIS_5_tdata(s_data[4]), .S_AXIS_5_tvalid(s_valid[4]),
        .S_AXIS_6_tdata(s_data[5]), .S_AXIS_6_tvalid(s_valid[5]),
        .trigger(trigger0), .channel_mask(channel_mask),
        .M_AXIS_tdata(m0_tdata), .M_AXIS_tvalid(m0_tvalid), .M_AXIS_tready(tready0),
        .M_AXIS_tlast(m0_tlast), .busy(busy0), .overrun_count(ovr0), .frame_count(fc0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitors: every presented beat (stalled or transferring) must match the
    // head of the scoreboard; the entry is retired only when it transfers.
    always @(negedge a_clk) begin
        if (!a_rst && m_tvalid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL hdr.unexpected_beat: got %h, required no beat", m_tdata);
            end else begin
                chk("hdr.beat_data", m_tdata, q[0].d);
                chk("hdr.beat_last", 32'(m_tlast), 32'(q[0].l));
                if (tready) void'(q.pop_front());
            end
        end
    end

    always @(negedge a_clk) begin
        if (!a_rst && m0_tvalid) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL nohdr.unexpected_beat: got %h, required no beat", m0_tdata);
            end else begin
                chk("nohdr.beat_data", m0_tdata, q0[0].d);
                chk("nohdr.beat_last", 32'(m0_tlast), 32'(q0[0].l));
                if (tready0) void'(q0.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge a_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        q.push_back({d, l});
    endtask

    task automatic set_data(input logic [31:0] base);
        for (int i = 0; i < 6; i++) s_data[i] = base + 32'(i + 1);
    endtask

    task automatic do_reset();
        a_rst = 1'b1;
        tick();
        tick();
        q.delete();
        q0.delete();
        a_rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || q0.size() != 0 || busy || busy0) && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s drain timeout: %0d/%0d beats outstanding, required 0",
                     name, q.size(), q0.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bp[7];
        bp = '{1, 0, 0, 1, 0, 1, 1};
        set_data(32'h1000_0000);
        // Only the enabled channels are flagged valid so the header reads 0x2525.
        s_valid = 6'b100101;

        // ---- reset state
        tick();
        tick();
        chk("rst.tvalid", 32'(m_tvalid), 32'd0);
        chk("rst.tlast", 32'(m_tlast), 32'd0);
        chk("rst.tdata", m_tdata, 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.frame_count", 32'(fc), 32'd0);
        chk("rst.overrun_count", 32'(ovr), 32'd0);
        a_rst = 1'b0;
        tick();

        // ---- basic frame
        push(32'h0000_2525, 1'b0);
        push(32'h1000_0001, 1'b0);
        push(32'h1000_0003, 1'b0);
        push(32'h1000_0006, 1'b1);
        channel_mask = 6'b100101;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("basic.tvalid_T+1", 32'(m_tvalid), 32'd1);
        chk("basic.busy_T+1", 32'(busy), 32'd1);
        wait_drain("basic");
        chk("basic.frame_count", 32'(fc), 32'd1);
        chk("basic.busy_after", 32'(busy), 32'd0);

        // ---- back-pressure
        push(32'h0001_2525, 1'b0);
        push(32'h1000_0001, 1'b0);
        push(32'h1000_0003, 1'b0);
        push(32'h1000_0006, 1'b1);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tready = bp[i][0];
            tick();
        end
        tready = 1'b1;
        chk("bp.queue_empty", 32'(q.size()), 32'd0);
        wait_drain("backpressure");
        chk("bp.frame_count", 32'(fc), 32'd2);

        // ---- overrun and back-to-back
        do_reset();
        push(32'h0000_2525, 1'b0);
        push(32'h1000_0001, 1'b0);
        push(32'h1000_0003, 1'b0);
        push(32'h1000_0006, 1'b1);
        push(32'h0001_2525, 1'b0);
        push(32'h2000_0001, 1'b0);
        push(32'h2000_0003, 1'b0);
        push(32'h2000_0006, 1'b1);
        trigger = 1'b1;
        tick();                     // header presented
        trigger = 1'b0;
        tick();                     // beat 2 presented
        trigger = 1'b1;
        tick();                     // trigger dropped, beat 3 presented
        trigger = 1'b0;
        chk("ovr.count_1", 32'(ovr), 32'd1);
        tick();                     // tlast beat presented
        chk("ovr.tlast_beat", 32'(m_tlast), 32'd1);
        set_data(32'h2000_0000);
        trigger = 1'b1;
        tick();                     // tlast transfers, new frame accepted
        trigger = 1'b0;
        set_data(32'h1000_0000);    // must not disturb the new snapshot
        chk("b2b.tvalid_no_gap", 32'(m_tvalid), 32'd1);
        chk("b2b.busy", 32'(busy), 32'd1);
        chk("b2b.overrun_unchanged", 32'(ovr), 32'd1);
        wait_drain("b2b");
        chk("b2b.frame_count", 32'(fc), 32'd2);

        // ---- zero mask
        channel_mask = 6'b000000;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("zero.busy", 32'(busy), 32'd0);
        chk("zero.tvalid", 32'(m_tvalid), 32'd0);
        tick();
        chk("zero.frame_count", 32'(fc), 32'd2);
        chk("zero.overrun", 32'(ovr), 32'd1);

        // ---- stale valid bit on channel 3
        s_valid = 6'b111011;
        channel_mask = 6'b000100;
        push(32'h0002_3B04, 1'b0);
        push(32'h1000_0003, 1'b1);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        s_valid = 6'b100101;
        wait_drain("stale");
        chk("stale.frame_count", 32'(fc), 32'd3);

        // ---- header off, single channel
        channel_mask = 6'b000001;
        q0.push_back({32'h1000_0001, 1'b1});
        trigger0 = 1'b1;
        tick();
        trigger0 = 1'b0;
        chk("nohdr.tvalid_T+1", 32'(m0_tvalid), 32'd1);
        chk("nohdr.tlast_single", 32'(m0_tlast), 32'd1);
        wait_drain("nohdr");
        chk("nohdr.frame_count", 32'(fc0), 32'd1);

        // ---- reset mid-frame
        channel_mask = 6'b100101;
        push(32'h0003_2525, 1'b0);
        push(32'h1000_0001, 1'b0);
        push(32'h1000_0003, 1'b0);
        push(32'h1000_0006, 1'b1);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();                     // beat 2 presented
        #2 a_rst = 1'b1;
        #1;
        chk("arst.tvalid", 32'(m_tvalid), 32'd0);
        chk("arst.tlast", 32'(m_tlast), 32'd0);
        chk("arst.tdata", m_tdata, 32'd0);
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.frame_count", 32'(fc), 32'd0);
        chk("arst.overrun", 32'(ovr), 32'd0);
        chk("arst.nohdr_frame_count", 32'(fc0), 32'd0);
        q.delete();
        tick();
        a_rst = 1'b0;
        tick();
        push(32'h0000_2525, 1'b0);
        push(32'h1000_0001, 1'b0);
        push(32'h1000_0003, 1'b0);
        push(32'h1000_0006, 1'b1);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        wait_drain("post_reset");
        chk("post_reset.frame_count", 32'(fc), 32'd1);

        // ---- overrun saturation (header DUT stalled) and frame_count wrap
        // (single-beat back-to-back frames on the header-less DUT)
        channel_mask = 6'b000001;
        push(32'h0001_2501, 1'b0);
        push(32'h1000_0001, 1'b1);
        for (int i = 0; i < 65536; i++) q0.push_back({32'h1000_0001, 1'b1});
        trigger = 1'b1;
        trigger0 = 1'b1;
        tick();
        tready = 1'b0;
        for (int i = 2; i <= 65536; i++) tick();
        chk("wrap.frame_count_ffff", 32'(fc0), 32'h0000_FFFF);
        trigger0 = 1'b0;
        tick();
        chk("wrap.frame_count_0", 32'(fc0), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("sat.overrun_ffff", 32'(ovr), 32'h0000_FFFF);
        trigger = 1'b0;
        tready = 1'b1;
        wait_drain("saturation");
        chk("sat.overrun_hold", 32'(ovr), 32'h0000_FFFF);
        chk("sat.frame_count", 32'(fc), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
